// File: rtl/voice_mixer_sched_if.sv
// Wavetable ROM read bus: the voice scheduler drives address/enable (master),
// a synchronous ROM returns data one cycle after enable (slave).
interface voice_mixer_sched_if #(
  parameter int ADDR_W   = 6,
  parameter int SAMPLE_W = 8
);
  logic [ADDR_W-1:0]   rom_addr;
  logic                rom_en;
  logic [SAMPLE_W-1:0] rom_data;

  modport master (output rom_addr, output rom_en, input rom_data);
  modport slave  (input rom_addr, input rom_en, output rom_data);
endinterface

// File: rtl/voice_mixer_sched.sv
// Polyphonic voice scheduler: per sample tick, walks the snapshot chord through one
// shared wavetable ROM, sums active voices into a saturated mix and advances phases.
module voice_mixer_sched #(
  parameter int NKEYS    = 8,
  parameter int PHASE_W  = 16,
  parameter int ADDR_W   = 6,
  parameter int SAMPLE_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NKEYS-1:0]    keys,
  input  logic                sample_tick,
  input  logic                inc_wr_en,
  input  logic [2:0]          inc_wr_idx,
  input  logic [PHASE_W-1:0]  inc_wr_data,
  voice_mixer_sched_if.master rom,
  output logic [SAMPLE_W-1:0] wave,
  output logic                wave_valid,
  output logic                busy,
  output logic                overrun
);
  localparam int IDX_W = 3;
  localparam int ACC_W = SAMPLE_W + 3;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NKEYS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t              state_r, state_s;
  logic [IDX_W-1:0]    idx_r, idx_s;
  logic [NKEYS-1:0]    chord_r, chord_s;
  logic                busy_r, busy_s;
  logic [SAMPLE_W-1:0] wave_r, wave_s;
  logic                wave_valid_r, wave_valid_s;
  logic                acc_clr_s;
  logic [ACC_W-1:0]    acc_r;
  logic                rom_en_s, rom_en_d_r;
  logic [ADDR_W-1:0]   rom_addr_s;
  logic                overrun_r;
  logic [PHASE_W-1:0]  phase_r [NKEYS];
  logic [PHASE_W-1:0]  inc_r   [NKEYS];

  function automatic logic [SAMPLE_W-1:0] saturate(input logic [ACC_W-1:0] a);
    if (|a[ACC_W-1:SAMPLE_W]) return {SAMPLE_W{1'b1}};
    else return a[SAMPLE_W-1:0];
  endfunction

  // Sequencer next state and next values of the registered outputs
  always_comb begin
    state_s      = state_r;
    idx_s        = idx_r;
    chord_s      = chord_r;
    busy_s       = busy_r;
    wave_s       = wave_r;
    wave_valid_s = 1'b0;
    acc_clr_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (sample_tick) begin
          state_s   = SCAN;
          chord_s   = keys;
          idx_s     = '0;
          busy_s    = 1'b1;
          acc_clr_s = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      SCAN: begin
        idx_s = idx_r + 3'd1;
        if (idx_r == LAST_IDX) state_s = DRAIN;
        else state_s = SCAN;
      end
      DRAIN: state_s = DONE;
      DONE: begin
        state_s      = IDLE;
        wave_s       = saturate(acc_r);
        wave_valid_s = 1'b1;
        busy_s       = 1'b0;
      end
      default: state_s = IDLE;
    endcase
  end

  // ROM request for the key in the current scan slot
  always_comb begin
    rom_en_s   = 1'b0;
    rom_addr_s = '0;
    if (state_r == SCAN) begin
      rom_en_s   = chord_r[idx_r];
      rom_addr_s = phase_r[idx_r][PHASE_W-1 -: ADDR_W];
    end else begin
      rom_en_s   = 1'b0;
      rom_addr_s = '0;
    end
  end

  // Control registers, accumulator and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      idx_r        <= '0;
      chord_r      <= '0;
      busy_r       <= 1'b0;
      wave_r       <= '0;
      wave_valid_r <= 1'b0;
      overrun_r    <= 1'b0;
      rom_en_d_r   <= 1'b0;
      acc_r        <= '0;
    end else begin
      state_r      <= state_s;
      idx_r        <= idx_s;
      chord_r      <= chord_s;
      busy_r       <= busy_s;
      wave_r       <= wave_s;
      wave_valid_r <= wave_valid_s;
      overrun_r    <= sample_tick && (state_r != IDLE);
      rom_en_d_r   <= rom_en_s;
      // rom_en_d_r marks the cycle in which the synchronous ROM presents data
      if (acc_clr_s) acc_r <= '0;
      else if (rom_en_d_r) acc_r <= acc_r + ACC_W'(rom.rom_data);
    end
  end

  // Per-key phase accumulators and configuration-side increments
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NKEYS; k++) begin
        phase_r[k] <= '0;
        inc_r[k]   <= '0;
      end
    end else begin
      if (inc_wr_en) inc_r[inc_wr_idx] <= inc_wr_data;
      if (state_r == SCAN) begin
        if (chord_r[idx_r]) phase_r[idx_r] <= phase_r[idx_r] + inc_r[idx_r];
        else phase_r[idx_r] <= '0;
      end
    end
  end

  assign rom.rom_en   = rom_en_s;
  assign rom.rom_addr = rom_addr_s;
  assign wave         = wave_r;
  assign wave_valid   = wave_valid_r;
  assign busy         = busy_r;
  assign overrun      = overrun_r;
endmodule

// File: tb/tb_voice_mixer_sched.sv
// Self-checking bench for voice_mixer_sched: synchronous ROM model plus a per-sample
// reference model of chord mixing, phase stepping and saturation.
module tb_voice_mixer_sched;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  keys = 8'd0;
  logic        sample_tick = 1'b0;
  logic        inc_wr_en = 1'b0;
  logic [2:0]  inc_wr_idx = 3'd0;
  logic [15:0] inc_wr_data = 16'd0;
  logic [7:0]  wave;
  logic        wave_valid, busy, overrun;

  int n_checks = 0;
  int n_fail   = 0;

  voice_mixer_sched_if #(.ADDR_W(6), .SAMPLE_W(8)) rom_if ();

  voice_mixer_sched dut (
    .clk(clk), .rst(rst), .keys(keys), .sample_tick(sample_tick),
    .inc_wr_en(inc_wr_en), .inc_wr_idx(inc_wr_idx), .inc_wr_data(inc_wr_data),
    .rom(rom_if), .wave(wave), .wave_valid(wave_valid), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // ROM contents selectable per test
  int         rom_mode = 0;
  logic [7:0] rom_const = 8'd0;

  function automatic logic [7:0] rom_fn(input logic [5:0] a);
    logic [7:0] a8;
    a8 = {2'b00, a};
    case (rom_mode)
      0: return 8'(a8 * 8'd4);
      1: return rom_const;
      default: return 8'(a8 * 8'd37 + 8'd11);
    endcase
  endfunction

  always @(posedge clk) if (rom_if.rom_en) rom_if.rom_data <= rom_fn(rom_if.rom_addr);

  // Reference state
  logic [15:0] phase_m [8];
  logic [15:0] inc_m   [8];
  logic [7:0]  exp_wave;
  int          exp_en;
  logic [5:0]  exp_last_addr;

  // Observations of one sample window (cycles 1..14 after the tick)
  int         busy_cnt, busy_first, en_cnt, valid_cnt, valid_cyc, ovr_cnt, ovr_cyc;
  logic [5:0] last_addr;
  logic [7:0] wave_at_valid, wave_end;

  task automatic model_reset();
    for (int j = 0; j < 8; j++) begin
      phase_m[j] = 16'd0;
      inc_m[j]   = 16'd0;
    end
  endtask

  task automatic write_inc(input logic [2:0] idx, input logic [15:0] data);
    inc_wr_en = 1'b1; inc_wr_idx = idx; inc_wr_data = data;
    @(negedge clk);
    inc_wr_en = 1'b0;
    inc_m[idx] = data;
  endtask

  // One tick at cycle 0, optional second tick / increment write / reset at given cycles
  task automatic run_sample(input logic [7:0] k, input int extra, input int wr_cyc,
                            input logic [2:0] wr_idx, input logic [15:0] wr_data,
                            input int rst_cyc);
    int sum;
    sum = 0; exp_en = 0; exp_last_addr = 6'd0;
    if (wr_cyc > 0 && wr_cyc <= int'(wr_idx)) inc_m[wr_idx] = wr_data;
    for (int j = 0; j < 8; j++) begin
      if (k[j]) begin
        exp_last_addr = phase_m[j][15:10];
        sum += int'(rom_fn(exp_last_addr));
        exp_en++;
        phase_m[j] = phase_m[j] + inc_m[j];
      end else begin
        phase_m[j] = 16'd0;
      end
    end
    exp_wave = (sum > 255) ? 8'd255 : 8'(sum);
    if (wr_cyc > 0 && wr_cyc > int'(wr_idx)) inc_m[wr_idx] = wr_data;
    if (rst_cyc > 0) model_reset();

    busy_cnt = 0; busy_first = 0; en_cnt = 0; valid_cnt = 0; valid_cyc = 0;
    ovr_cnt = 0; ovr_cyc = 0; last_addr = 6'd0; wave_at_valid = 8'd0;
    keys = k; sample_tick = 1'b1;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      if (busy) begin busy_cnt++; if (busy_first == 0) busy_first = c; end
      if (rom_if.rom_en) begin en_cnt++; last_addr = rom_if.rom_addr; end
      if (wave_valid) begin valid_cnt++; valid_cyc = c; wave_at_valid = wave; end
      if (overrun) begin ovr_cnt++; ovr_cyc = c; end
      sample_tick = (c == extra);
      keys        = 8'($urandom);
      inc_wr_en   = (c == wr_cyc);
      inc_wr_idx  = wr_idx;
      inc_wr_data = wr_data;
      rst         = (c == rst_cyc);
    end
    wave_end = wave;
    sample_tick = 1'b0; inc_wr_en = 1'b0; rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    n_checks++; if (wave !== 8'd0) begin n_fail++; $display("FAIL reset_wave got=%0d exp=0", wave); end
    n_checks++; if (wave_valid !== 1'b0) begin n_fail++; $display("FAIL reset_wave_valid got=%0b exp=0", wave_valid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun got=%0b exp=0", overrun); end
    n_checks++; if (rom_if.rom_en !== 1'b0) begin n_fail++; $display("FAIL reset_rom_en got=%0b exp=0", rom_if.rom_en); end
    n_checks++; if (rom_if.rom_addr !== 6'd0) begin n_fail++; $display("FAIL reset_rom_addr got=%0d exp=0", rom_if.rom_addr); end
  endtask

  task automatic test_no_keys();
    rom_mode = 2;
    run_sample(8'h00, 0, 0, 3'd0, 16'd0, 0);
    n_checks++; if (en_cnt !== 0) begin n_fail++; $display("FAIL nokeys_rom_en got=%0d exp=0", en_cnt); end
    n_checks++; if (busy_first !== 1) begin n_fail++; $display("FAIL nokeys_busy_first got=%0d exp=1", busy_first); end
    n_checks++; if (busy_cnt !== 10) begin n_fail++; $display("FAIL nokeys_busy_cycles got=%0d exp=10", busy_cnt); end
    n_checks++; if (valid_cnt !== 1) begin n_fail++; $display("FAIL nokeys_valid_count got=%0d exp=1", valid_cnt); end
    n_checks++; if (valid_cyc !== 11) begin n_fail++; $display("FAIL nokeys_valid_cycle got=%0d exp=11", valid_cyc); end
    n_checks++; if (wave_at_valid !== 8'd0) begin n_fail++; $display("FAIL nokeys_wave got=%0d exp=0", wave_at_valid); end
  endtask

  task automatic test_sweep();
    logic [5:0] ea;
    rom_mode = 0;
    write_inc(3'd2, 16'h0400);
    for (int i = 0; i < 66; i++) begin
      ea = 6'(i % 64);
      run_sample(8'h04, 0, 0, 3'd0, 16'd0, 0);
      n_checks++; if (last_addr !== ea) begin n_fail++; $display("FAIL sweep_addr tick=%0d got=%0d exp=%0d", i, last_addr, ea); end
      n_checks++; if (wave_at_valid !== 8'(ea * 4)) begin n_fail++; $display("FAIL sweep_wave tick=%0d got=%0d exp=%0d", i, wave_at_valid, 8'(ea * 4)); end
    end
    n_checks++; if (wave_end !== wave_at_valid) begin n_fail++; $display("FAIL sweep_wave_hold got=%0d exp=%0d", wave_end, wave_at_valid); end
  endtask

  task automatic test_saturate();
    logic [7:0] cv [4];
    logic [7:0] kv [4];
    logic [7:0] ev [4];
    cv = '{8'd100, 8'd200, 8'd85, 8'd64};
    kv = '{8'h03, 8'hFF, 8'h07, 8'h0F};
    ev = '{8'd200, 8'd255, 8'd255, 8'd255};
    rom_mode = 1;
    for (int i = 0; i < 4; i++) begin
      rom_const = cv[i];
      run_sample(kv[i], 0, 0, 3'd0, 16'd0, 0);
      n_checks++; if (wave_at_valid !== ev[i]) begin n_fail++; $display("FAIL saturate case=%0d got=%0d exp=%0d", i, wave_at_valid, ev[i]); end
    end
  endtask

  task automatic test_overrun();
    int ex [3];
    ex = '{5, 10, 1};
    rom_mode = 2;
    for (int i = 0; i < 3; i++) begin
      run_sample(8'($urandom), ex[i], 0, 3'd0, 16'd0, 0);
      n_checks++; if (ovr_cnt !== 1 || ovr_cyc !== ex[i] + 1) begin n_fail++; $display("FAIL overrun_pulse tick_at=%0d got_count=%0d got_cycle=%0d exp_cycle=%0d", ex[i], ovr_cnt, ovr_cyc, ex[i] + 1); end
      n_checks++; if (valid_cnt !== 1 || valid_cyc !== 11) begin n_fail++; $display("FAIL overrun_single_output got_count=%0d got_cycle=%0d exp=1@11", valid_cnt, valid_cyc); end
      n_checks++; if (busy_cnt !== 10) begin n_fail++; $display("FAIL overrun_not_queued got_busy=%0d exp=10", busy_cnt); end
      n_checks++; if (wave_at_valid !== exp_wave) begin n_fail++; $display("FAIL overrun_wave got=%0d exp=%0d", wave_at_valid, exp_wave); end
    end
  endtask

  task automatic test_release();
    rom_mode = 2;
    write_inc(3'd2, {6'($urandom_range(1, 63)), 10'd0});
    for (int i = 0; i < 3; i++) run_sample(8'h04, 0, 0, 3'd0, 16'd0, 0);
    run_sample(8'h00, 0, 0, 3'd0, 16'd0, 0);
    n_checks++; if (wave_at_valid !== 8'd0 || en_cnt !== 0) begin n_fail++; $display("FAIL release_silent got_wave=%0d got_en=%0d exp=0", wave_at_valid, en_cnt); end
    run_sample(8'h04, 0, 0, 3'd0, 16'd0, 0);
    n_checks++; if (last_addr !== 6'd0) begin n_fail++; $display("FAIL repress_addr got=%0d exp=0", last_addr); end
    n_checks++; if (wave_at_valid !== 8'd11) begin n_fail++; $display("FAIL repress_wave got=%0d exp=11", wave_at_valid); end
  endtask

  task automatic test_inc_write_busy();
    rom_mode = 2;
    for (int c = 1; c <= 6; c++) begin
      run_sample(8'h04, 0, c, 3'd2, {6'($urandom_range(1, 63)), 10'd0}, 0);
      n_checks++; if (wave_at_valid !== exp_wave) begin n_fail++; $display("FAIL incwr_wave cyc=%0d got=%0d exp=%0d", c, wave_at_valid, exp_wave); end
      run_sample(8'h04, 0, 0, 3'd0, 16'd0, 0);
      n_checks++; if (last_addr !== exp_last_addr) begin n_fail++; $display("FAIL incwr_next_addr cyc=%0d got=%0d exp=%0d", c, last_addr, exp_last_addr); end
    end
  endtask

  task automatic test_reset_mid_scan();
    rom_mode = 2;
    write_inc(3'd2, 16'h0400);
    run_sample(8'h0C, 0, 0, 3'd0, 16'd0, 0);
    run_sample(8'h0C, 0, 0, 3'd0, 16'd0, 4);
    n_checks++; if (valid_cnt !== 0) begin n_fail++; $display("FAIL rstscan_no_valid got=%0d exp=0", valid_cnt); end
    n_checks++; if (busy_cnt !== 4) begin n_fail++; $display("FAIL rstscan_busy got=%0d exp=4", busy_cnt); end
    n_checks++; if (wave_end !== 8'd0) begin n_fail++; $display("FAIL rstscan_wave got=%0d exp=0", wave_end); end
    write_inc(3'd2, 16'h0400);
    run_sample(8'h04, 0, 0, 3'd0, 16'd0, 0);
    n_checks++; if (last_addr !== 6'd0) begin n_fail++; $display("FAIL rstscan_phase_restart got=%0d exp=0", last_addr); end
    n_checks++; if (valid_cyc !== 11 || wave_at_valid !== 8'd11) begin n_fail++; $display("FAIL rstscan_next_sample got_cycle=%0d got_wave=%0d exp=11/11", valid_cyc, wave_at_valid); end
  endtask

  task automatic test_random();
    int wc, ex;
    for (int i = 0; i < 40; i++) begin
      rom_mode = ($urandom_range(0, 1) == 0) ? 0 : 2;
      wc = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 12));
      ex = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 10)) : 0;
      run_sample(8'($urandom), ex, wc, 3'($urandom), 16'($urandom), 0);
      n_checks++; if (wave_at_valid !== exp_wave) begin n_fail++; $display("FAIL random_wave iter=%0d got=%0d exp=%0d", i, wave_at_valid, exp_wave); end
      n_checks++; if (en_cnt !== exp_en) begin n_fail++; $display("FAIL random_rom_reads iter=%0d got=%0d exp=%0d", i, en_cnt, exp_en); end
      n_checks++; if (valid_cyc !== 11) begin n_fail++; $display("FAIL random_latency iter=%0d got=%0d exp=11", i, valid_cyc); end
    end
  endtask

  initial begin
    test_reset();
    test_no_keys();
    test_sweep();
    test_saturate();
    test_overrun();
    test_release();
    test_inc_write_busy();
    test_reset_mid_scan();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
